// File: rtl/fp32_pkg.sv
// -----------------------------------------------------------------------------
// fp32_pkg
//   Shared definitions for the fp32 -> int32 conversion pipeline:
//   exponent bias, field widths, operand class encoding, the exception-flag
//   layout, integer saturation limits and a small classification helper.
// -----------------------------------------------------------------------------
package fp32_pkg;

    localparam int BIAS   = 127;
    localparam int EXP_W  = 8;
    localparam int MANT_W = 23;
    localparam int SIG_W  = MANT_W + 1;   // significand with hidden bit
    localparam int INT_W  = 32;

    localparam logic [INT_W-1:0] INT_MAX = 32'h7FFF_FFFF;
    localparam logic [INT_W-1:0] INT_MIN = 32'h8000_0000;

    // Operand class decided in the unpack stage.
    typedef enum logic [1:0] {
        ZERO   = 2'd0,   // zero or denormal (exp == 0)
        NORMAL = 2'd1,
        INF    = 2'd2,
        NAN    = 2'd3
    } fp_class_e;

    // Exception flags, packed so that the vector reads {invalid, overflow, inexact}.
    typedef struct packed {
        logic invalid;
        logic overflow;
        logic inexact;
    } fp_flags_t;

    function automatic fp_class_e classify(input logic [EXP_W-1:0]  exp_f,
                                           input logic [MANT_W-1:0] mant_f);
        if (exp_f == '1) begin
            return (mant_f != '0) ? NAN : INF;
        end else if (exp_f == '0) begin
            return ZERO;
        end
        return NORMAL;
    endfunction

endpackage

// File: rtl/align_shifter.sv
// -----------------------------------------------------------------------------
// align_shifter
//   Combinational alignment of a 24-bit significand {1, mant} to an integer
//   magnitude, driven by the unbiased exponent e.
//     e < 0        : magnitude 0, sticky = 1 (the hidden bit is always lost)
//     0 <= e <= 23 : right shift by 23 - e, sticky = OR of discarded bits
//     24 <= e <= 30: left shift by e - 23, exact
//     e >= 31      : magnitude 0, sticky 0 (caller handles overflow)
//
// Ports
//   sig_i    [23:0]  significand including the hidden bit
//   e_i      [8:0]   signed unbiased exponent
//   mag_o    [31:0]  aligned unsigned magnitude
//   sticky_o         at least one significand bit was shifted out
// -----------------------------------------------------------------------------
module align_shifter
    import fp32_pkg::*;
(
    input  logic [SIG_W-1:0]        sig_i,
    input  logic signed [EXP_W:0]   e_i,
    output logic [INT_W-1:0]        mag_o,
    output logic                    sticky_o
);

    // Right shifts go through a double-width window so the discarded bits
    // land in the low half and can be OR-reduced for the sticky bit.
    logic [2*SIG_W-1:0] rwin;
    logic [4:0]         rsh;
    logic [2:0]         lsh;

    always_comb begin
        mag_o    = '0;
        sticky_o = 1'b0;
        rwin     = '0;
        // Only the low exponent bits matter inside each branch's range:
        // 23 - e and e - 23 are taken modulo 32 and 8 respectively.
        rsh      = 5'd23 - e_i[4:0];
        lsh      = e_i[2:0] - 3'd7;

        if (e_i < 9'sd0) begin
            sticky_o = |sig_i;
        end else if (e_i <= 9'sd23) begin
            rwin     = {sig_i, {SIG_W{1'b0}}} >> rsh;
            mag_o    = {{(INT_W-SIG_W){1'b0}}, rwin[2*SIG_W-1:SIG_W]};
            sticky_o = |rwin[SIG_W-1:0];
        end else if (e_i <= 9'sd30) begin
            mag_o = {{(INT_W-SIG_W){1'b0}}, sig_i} << lsh;
        end
    end

endmodule

// File: rtl/fp32_to_int32_pipe.sv
// -----------------------------------------------------------------------------
// fp32_to_int32_pipe
//   Three-stage IEEE-754 single precision to signed 32-bit integer converter.
//   Round toward zero, saturation on overflow, {invalid, overflow, inexact}
//   flags. All stages advance together whenever the output stage is empty or
//   being drained; otherwise the whole pipe holds.
//
//   S1  unpack and classify
//   S2  align significand (align_shifter), detect overflow
//   S3  apply sign, saturate, form flags
//
// Ports
//   clk        clock, rising edge
//   rst_n      asynchronous active-low reset
//   in_valid   in_data holds an operand
//   in_ready   operand accepted this cycle (depends only on S3 state/out_ready)
//   in_data    fp32 operand {sign, exp[7:0], mant[22:0]}
//   out_valid  out_data/out_flags hold a result
//   out_ready  downstream accepts the result
//   out_data   two's-complement integer result
//   out_flags  {invalid, overflow, inexact}
// -----------------------------------------------------------------------------
module fp32_to_int32_pipe #(
    parameter int BIAS   = 127,
    parameter int STAGES = 3      // fixed depth, not configurable
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [31:0] in_data,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] out_data,
    output logic [2:0]  out_flags
);

    import fp32_pkg::*;

    // ------------------------------------------------------------------
    // Handshake: one valid bit per stage, shifted as a unit.
    // ------------------------------------------------------------------
    logic [STAGES-1:0] valid_q, valid_d;
    logic              advance;

    assign advance   = !valid_q[STAGES-1] || out_ready;
    assign in_ready  = advance;
    assign out_valid = valid_q[STAGES-1];

    always_comb begin
        valid_d = valid_q;
        if (advance) begin
            valid_d = {valid_q[STAGES-2:0], in_valid};
        end
    end

    // ------------------------------------------------------------------
    // S1: unpack and classify
    // ------------------------------------------------------------------
    logic              s1_sign_q, s1_sign_d;
    logic [EXP_W-1:0]  s1_exp_q,  s1_exp_d;
    logic [MANT_W-1:0] s1_mant_q, s1_mant_d;
    fp_class_e         s1_class_q, s1_class_d;

    always_comb begin
        s1_sign_d  = in_data[31];
        s1_exp_d   = in_data[30:23];
        s1_mant_d  = in_data[22:0];
        s1_class_d = classify(in_data[30:23], in_data[22:0]);
    end

    // ------------------------------------------------------------------
    // S2: align
    // ------------------------------------------------------------------
    logic signed [EXP_W:0] s1_e;
    logic [INT_W-1:0]      sh_mag;
    logic                  sh_sticky;

    assign s1_e = $signed({1'b0, s1_exp_q}) - $signed(9'(BIAS));

    align_shifter u_align_shifter (
        .sig_i    ({1'b1, s1_mant_q}),
        .e_i      (s1_e),
        .mag_o    (sh_mag),
        .sticky_o (sh_sticky)
    );

    logic             s2_sign_q,    s2_sign_d;
    fp_class_e        s2_class_q,   s2_class_d;
    logic [INT_W-1:0] s2_mag_q,     s2_mag_d;
    logic             s2_inexact_q, s2_inexact_d;
    logic             s2_ovf_q,     s2_ovf_d;
    logic             s2_min_q,     s2_min_d;   // operand is exactly -2^31

    always_comb begin
        s2_sign_d    = s1_sign_q;
        s2_class_d   = s1_class_q;
        s2_mag_d     = '0;
        s2_inexact_d = 1'b0;
        s2_ovf_d     = 1'b0;
        s2_min_d     = 1'b0;
        unique case (s1_class_q)
            NORMAL: begin
                s2_mag_d     = sh_mag;
                s2_inexact_d = sh_sticky;
                s2_ovf_d     = (s1_e >= 9'sd31);
                // -2^31 is representable even though its exponent
                // is in the overflow range.
                s2_min_d     = s1_sign_q && (s1_e == 9'sd31) && (s1_mant_q == '0);
            end
            ZERO: begin
                // Denormals truncate to zero; only a nonzero fraction is inexact.
                s2_inexact_d = (s1_mant_q != '0);
            end
            default: ;
        endcase
    end

    // ------------------------------------------------------------------
    // S3: sign and saturate
    // ------------------------------------------------------------------
    logic [INT_W-1:0] out_data_q, out_data_d;
    fp_flags_t        out_flags_q, out_flags_d;
    logic [INT_W-1:0] sat_val;

    assign sat_val = s2_sign_q ? INT_MIN : INT_MAX;

    always_comb begin
        out_data_d  = '0;
        out_flags_d = '0;
        unique case (s2_class_q)
            NAN: begin
                out_data_d          = INT_MAX;
                out_flags_d.invalid = 1'b1;
            end
            INF: begin
                out_data_d           = sat_val;
                out_flags_d.overflow = 1'b1;
            end
            ZERO: begin
                out_flags_d.inexact = s2_inexact_q;
            end
            default: begin
                if (s2_min_q) begin
                    out_data_d = INT_MIN;
                end else if (s2_ovf_q) begin
                    out_data_d           = sat_val;
                    out_flags_d.overflow = 1'b1;
                end else begin
                    out_data_d          = s2_sign_q ? (~s2_mag_q + 32'd1) : s2_mag_q;
                    out_flags_d.inexact = s2_inexact_q;
                end
            end
        endcase
    end

    assign out_data  = out_data_q;
    assign out_flags = out_flags_q;

    // ------------------------------------------------------------------
    // Pipeline registers: everything moves on advance, nothing otherwise.
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid_q      <= '0;
            s1_sign_q    <= 1'b0;
            s1_exp_q     <= '0;
            s1_mant_q    <= '0;
            s1_class_q   <= ZERO;
            s2_sign_q    <= 1'b0;
            s2_class_q   <= ZERO;
            s2_mag_q     <= '0;
            s2_inexact_q <= 1'b0;
            s2_ovf_q     <= 1'b0;
            s2_min_q     <= 1'b0;
            out_data_q   <= '0;
            out_flags_q  <= '0;
        end else begin
            valid_q <= valid_d;
            if (advance) begin
                s1_sign_q    <= s1_sign_d;
                s1_exp_q     <= s1_exp_d;
                s1_mant_q    <= s1_mant_d;
                s1_class_q   <= s1_class_d;
                s2_sign_q    <= s2_sign_d;
                s2_class_q   <= s2_class_d;
                s2_mag_q     <= s2_mag_d;
                s2_inexact_q <= s2_inexact_d;
                s2_ovf_q     <= s2_ovf_d;
                s2_min_q     <= s2_min_d;
                out_data_q   <= out_data_d;
                out_flags_q  <= out_flags_d;
            end
        end
    end

endmodule

// File: tb/tb_fp32_to_int32_pipe.sv
// -----------------------------------------------------------------------------
// tb_fp32_to_int32_pipe
//   Randomised and directed stimulus for fp32_to_int32_pipe. Expected results
//   come from a value-level conversion model; a single compare process checks
//   every transferred result in order and the stability of held results.
// -----------------------------------------------------------------------------
module tb_fp32_to_int32_pipe;

    logic        clk;
    logic        rst_n;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] in_data;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_data;
    logic [2:0]  out_flags;

    int checks = 0;
    int errors = 0;
    int acc_cnt = 0;
    int out_cnt = 0;

    logic [34:0] exp_q[$];   // {data, flags}

    fp32_to_int32_pipe dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .out_flags (out_flags)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // Value-level reference: real number semantics, truncate toward zero,
    // saturate outside [-2^31, 2^31-1].
    function automatic logic [34:0] model(input logic [31:0] f);
        logic        s;
        int          ex;
        longint      mt, sig, mag;
        int          e;
        logic [31:0] r;
        logic        inv, ovf, inx;
        s   = f[31];
        ex  = int'(f[30:23]);
        mt  = longint'(f[22:0]);
        r   = 32'd0;
        inv = 1'b0; ovf = 1'b0; inx = 1'b0;
        if (ex == 255) begin
            if (mt != 0) begin
                r = 32'h7FFF_FFFF; inv = 1'b1;
            end else begin
                r = s ? 32'h8000_0000 : 32'h7FFF_FFFF; ovf = 1'b1;
            end
        end else if (ex == 0) begin
            inx = (mt != 0);
        end else begin
            e   = ex - 127;
            sig = 64'd8388608 + mt;              // 2^23 + fraction
            if (e >= 31) begin
                if (s && e == 31 && mt == 0) begin
                    r = 32'h8000_0000;
                end else begin
                    r = s ? 32'h8000_0000 : 32'h7FFF_FFFF; ovf = 1'b1;
                end
            end else begin
                if (e >= 23) begin
                    mag = sig * (64'd1 << (e - 23));
                end else if (e >= 0) begin
                    mag = sig / (64'd1 << (23 - e));
                    inx = (mag * (64'd1 << (23 - e))) != sig;
                end else begin
                    mag = 0; inx = 1'b1;
                end
                r = s ? 32'(-mag) : 32'(mag);
            end
        end
        return {r, inv, ovf, inx};
    endfunction

    function automatic logic [31:0] gen_operand();
        logic        s;
        logic [7:0]  ex;
        logic [22:0] m;
        s  = 1'($urandom_range(0, 1));
        m  = 23'($urandom);
        ex = 8'd0;
        case ($urandom_range(0, 7))
            0:          return $urandom;
            1, 2, 3, 4: ex = 8'($urandom_range(100, 165));
            5:          ex = 8'd0;
            6:          ex = 8'd255;
            default: begin
                ex = 8'($urandom_range(150, 160));
                m  = '0;
            end
        endcase
        return {s, ex, m};
    endfunction

    task automatic fail(input string name, input logic [31:0] got, input logic [31:0] want);
        errors++;
        $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, got, want, $time);
    endtask

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] want);
        checks++;
        if (got !== want) fail(name, got, want);
    endtask

    // Compare process: sampled on the falling edge, where every handshake
    // signal is stable for the next rising edge.
    initial begin : compare_proc
        logic        hold_v;
        logic [31:0] hold_d;
        logic [2:0]  hold_f;
        logic [34:0] e;
        hold_v = 1'b0;
        hold_d = '0;
        hold_f = '0;
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                exp_q.delete();
                hold_v = 1'b0;
            end else begin
                if (hold_v) begin
                    check("hold_valid", 32'(out_valid), 32'd1);
                    check("hold_data", out_data, hold_d);
                    check("hold_flags", 32'(out_flags), 32'(hold_f));
                end
                if (out_valid && out_ready) begin
                    out_cnt++;
                    if (exp_q.size() == 0) begin
                        checks++;
                        fail("unexpected_result", out_data, 32'd0);
                    end else begin
                        e = exp_q.pop_front();
                        check("result_data", out_data, e[34:3]);
                        check("result_flags", 32'(out_flags), 32'(e[2:0]));
                    end
                end
                hold_v = out_valid && !out_ready;
                hold_d = out_data;
                hold_f = out_flags;
                if (in_valid && in_ready) begin
                    exp_q.push_back(model(in_data));
                    acc_cnt++;
                end
            end
            $display("cycle t=%0t in_v=%0b in_r=%0b in=0x%08h out_v=%0b out_r=%0b out=0x%08h flags=%03b",
                     $time, in_valid, in_ready, in_data, out_valid, out_ready, out_data, out_flags);
        end
    end

    // Single operand on an idle pipe with out_ready high; checks latency and
    // the hand-computed result.
    task automatic directed(input logic [31:0] f, input logic [31:0] want_d, input logic [2:0] want_f);
        int lat;
        @(posedge clk); #1;
        out_ready = 1'b1;
        in_valid  = 1'b1;
        in_data   = f;
        @(posedge clk);              // accept edge
        lat = 1;
        #1;
        in_valid = 1'b0;
        in_data  = $urandom;
        @(negedge clk);
        while (!out_valid && lat < 10) begin
            @(posedge clk);
            lat++;
            @(negedge clk);
        end
        check("latency", 32'(lat), 32'd3);
        check("directed_data", out_data, want_d);
        check("directed_flags", 32'(out_flags), 32'(want_f));
    endtask

    task automatic drain();
        int n;
        n = 0;
        in_valid  = 1'b0;
        out_ready = 1'b1;
        while ((exp_q.size() != 0 || out_valid) && n < 100) begin
            @(negedge clk);
            n++;
        end
        check("drain_empty", 32'(exp_q.size()), 32'd0);
    endtask

    logic [31:0] dir_in   [14] = '{32'h3FC0_0000, 32'hC5FA_0000, 32'h8000_0000, 32'h0000_0001,
                                   32'hCF00_0000, 32'h4F00_0000, 32'hFF80_0000, 32'h7FC0_0000,
                                   32'hFFC0_0001, 32'h7F80_0000, 32'h4B00_0001, 32'h4EFF_FFFF,
                                   32'h3F7F_FFFF, 32'hCF00_0001};
    logic [31:0] dir_data [14] = '{32'h0000_0001, 32'hFFFF_E0C0, 32'h0000_0000, 32'h0000_0000,
                                   32'h8000_0000, 32'h7FFF_FFFF, 32'h8000_0000, 32'h7FFF_FFFF,
                                   32'h7FFF_FFFF, 32'h7FFF_FFFF, 32'h0080_0001, 32'h7FFF_FF80,
                                   32'h0000_0000, 32'h8000_0000};
    logic [2:0]  dir_flag [14] = '{3'b001, 3'b000, 3'b000, 3'b001,
                                   3'b000, 3'b010, 3'b010, 3'b100,
                                   3'b100, 3'b010, 3'b000, 3'b000,
                                   3'b001, 3'b010};

    initial begin : stimulus
        int acc0, out0, guard;
        logic saw_stall;
        rst_n     = 1'b0;
        in_valid  = 1'b0;
        in_data   = '0;
        out_ready = 1'b0;
        #12;
        check("reset_out_valid", 32'(out_valid), 32'd0);
        check("reset_out_data", out_data, 32'd0);
        check("reset_out_flags", 32'(out_flags), 32'd0);
        check("reset_in_ready", 32'(in_ready), 32'd1);
        #11 rst_n = 1'b1;

        // Directed operands and boundaries.
        for (int i = 0; i < 14; i++) begin
            directed(dir_in[i], dir_data[i], dir_flag[i]);
        end
        drain();

        // Backpressure: 6 back-to-back operands, out_ready low for 5 cycles.
        @(posedge clk); #1;
        out_ready = 1'b0;
        acc0      = acc_cnt;
        out0      = out_cnt;
        saw_stall = 1'b0;
        fork
            begin
                for (int i = 0; i < 6; i++) begin
                    in_valid = 1'b1;
                    in_data  = gen_operand();
                    guard    = 0;
                    @(negedge clk);
                    while (!in_ready && guard < 50) begin
                        if (!saw_stall) begin
                            saw_stall = 1'b1;
                            check("stall_after_three", 32'(acc_cnt - acc0), 32'd3);
                        end
                        guard++;
                        @(negedge clk);
                    end
                    @(posedge clk); #1;
                end
                in_valid = 1'b0;
            end
            begin
                repeat (5) @(posedge clk);
                #1 out_ready = 1'b1;
            end
        join
        check("stall_seen", 32'(saw_stall), 32'd1);
        drain();
        check("bp_results", 32'(out_cnt - out0), 32'd6);

        // Reset with two operands in flight.
        @(posedge clk); #1;
        out_ready = 1'b1;
        in_valid  = 1'b1;
        in_data   = 32'h4120_0000;       // 10.0
        @(posedge clk); #1;
        in_data   = 32'hC120_0000;       // -10.0
        @(posedge clk); #1;
        in_valid  = 1'b0;
        #1 rst_n  = 1'b0;
        #1;
        check("midreset_out_valid", 32'(out_valid), 32'd0);
        check("midreset_out_data", out_data, 32'd0);
        check("midreset_in_ready", 32'(in_ready), 32'd1);
        @(negedge clk);
        @(negedge clk);
        #2 rst_n = 1'b1;
        out0 = out_cnt;
        repeat (6) @(negedge clk);
        check("no_stale_results", 32'(out_cnt - out0), 32'd0);
        directed(32'h42F6_E979, 32'h0000_007B, 3'b001);   // 123.456 -> 123
        drain();

        // Randomised traffic with random backpressure.
        for (int c = 0; c < 600; c++) begin
            @(posedge clk); #1;
            in_valid  = ($urandom_range(0, 3) != 0);
            in_data   = gen_operand();
            out_ready = ($urandom_range(0, 3) != 0);
        end
        @(posedge clk); #1;
        drain();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
